video_timing_gen: RTL and testbench

//  Parametrised successor to system_clock: derives the pixel-clock enable from clk,

---
 rtl/video_timing_gen.sv | 130 +++++++++++++
 tb/tb_video_timing_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-clock enable, H/V/frame counters, blank/sync
// decode and vblank / scanline-compare interrupts with level acks.
// Every output is a flop; decodes are taken from the next-count values so they
// line up with the counters they describe on every clk.
module video_timing_gen #(
  parameter int CLK_DIV      = 14,
  parameter int H_TOTAL      = 456,
  parameter int H_ACTIVE     = 336,
  parameter int H_SYNC_START = 368,
  parameter int H_SYNC_LEN   = 32,
  parameter int V_TOTAL      = 262,
  parameter int V_ACTIVE     = 240,
  parameter int V_SYNC_START = 248,
  parameter int V_SYNC_LEN   = 3,
  parameter int SYNC_POL     = 1,
  parameter int HW           = 9,
  parameter int VW           = 9,
  parameter int FW           = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          VBKACK_b,
  input  logic [VW-1:0] LINE_CMP,
  input  logic          LINE_EN,
  input  logic          LINEACK_b,
  output logic          MCKR_EN,
  output logic [HW-1:0] CLKH,
  output logic [VW-1:0] CLKV,
  output logic          HBLANK_b,
  output logic          VBLANK_b,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          NXL_b,
  output logic          VBKINT_b,
  output logic          LINEINT_b,
  output logic [FW-1:0] FRAME
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  // Sync level while inside the window; outside it is the inverse.
  localparam logic SP = (SYNC_POL != 0);

  // Geometry sanity: bad parameter sets stop elaboration.
  if (CLK_DIV < 2) begin : g_chk_div
    $error("video_timing_gen: CLK_DIV must be >= 2");
  end
  if (H_ACTIVE >= H_TOTAL || V_ACTIVE >= V_TOTAL) begin : g_chk_act
    $error("video_timing_gen: active region must be smaller than total");
  end
  if (H_SYNC_START + H_SYNC_LEN > H_TOTAL || V_SYNC_START + V_SYNC_LEN > V_TOTAL) begin : g_chk_sync
    $error("video_timing_gen: sync window runs past the raster wrap");
  end
  if (H_TOTAL > (1 << HW) || V_TOTAL > (1 << VW)) begin : g_chk_w
    $error("video_timing_gen: counter widths too small for geometry");
  end

  logic [DW-1:0] div_q;
  logic          tick;
  logic [HW-1:0] h_nx;
  logic [VW-1:0] v_nx;
  logic [FW-1:0] f_nx;
  logic          hs_win, vs_win, line0, vset, lset;

  // Next raster position: advance only on the divider's last clk.
  always_comb begin
    tick = (div_q == DIV_LAST);
    h_nx = CLKH;
    v_nx = CLKV;
    f_nx = FRAME;
    if (tick) begin
      if (CLKH == H_LAST) begin
        h_nx = '0;
        if (CLKV == V_LAST) begin
          v_nx = '0;
          f_nx = FRAME + 1'b1;
        end else begin
          v_nx = CLKV + 1'b1;
        end
      end else begin
        h_nx = CLKH + 1'b1;
      end
    end
  end

  // Decode windows and interrupt set events from the next position.
  always_comb begin
    hs_win = (int'(h_nx) >= H_SYNC_START) && (int'(h_nx) < H_SYNC_START + H_SYNC_LEN);
    vs_win = (int'(v_nx) >= V_SYNC_START) && (int'(v_nx) < V_SYNC_START + V_SYNC_LEN);
    line0  = tick && (h_nx == '0);
    vset   = line0 && (v_nx == V_ACT);
    // v_nx never reaches V_TOTAL, so out-of-range compare values never match.
    lset   = line0 && LINE_EN && (v_nx == LINE_CMP);
  end

  // All state and registered outputs; interrupt set beats a same-clk ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      MCKR_EN   <= 1'b0;
      CLKH      <= '0;
      CLKV      <= '0;
      FRAME     <= '0;
      HBLANK_b  <= 1'b1;
      VBLANK_b  <= 1'b1;
      HSYNC     <= ~SP;
      VSYNC     <= ~SP;
      NXL_b     <= 1'b1;
      VBKINT_b  <= 1'b1;
      LINEINT_b <= 1'b1;
    end else begin
      div_q     <= tick ? '0 : div_q + 1'b1;
      MCKR_EN   <= tick;
      CLKH      <= h_nx;
      CLKV      <= v_nx;
      FRAME     <= f_nx;
      HBLANK_b  <= (int'(h_nx) < H_ACTIVE);
      VBLANK_b  <= (int'(v_nx) < V_ACTIVE);
      HSYNC     <= hs_win ~^ SP;
      VSYNC     <= vs_win ~^ SP;
      NXL_b     <= (h_nx != H_LAST);
      VBKINT_b  <= ~(vset | (~VBKINT_b & VBKACK_b));
      LINEINT_b <= ~(lset | (~LINEINT_b & LINEACK_b));
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  typedef struct packed {
    logic       mck;
    logic [8:0] h;
    logic [8:0] v;
    logic       hb, vb, hs, vs, nxl, vint, lint;
    logic [7:0] frame;
  } out_t;

  typedef struct {
    int div, ht, ha, hss, hsl, vt, va, vss, vsl, pol, fw;
  } geom_t;

  localparam int N    = 3;
  localparam int NCYC = 50000;
  localparam int MAXF = 40;

  geom_t G[N];
  logic  clk = 1'b0;
  logic  rst = 1'b1;
  always #5 clk = ~clk;

  logic       ackv[N], ackl[N], len[N];
  logic [8:0] lcmp[N];
  logic       mck[N], hb[N], vb[N], hs[N], vs[N], nxl[N], vint[N], lint[N];
  logic [8:0] clkh[N], clkv[N];
  logic [7:0] fr_a;
  logic [2:0] fr_b;
  logic [3:0] fr_c;
  out_t       act[N];
  out_t       sbq[N][$];
  int         checks = 0;
  int         failures = 0;

  video_timing_gen u_a (
    .clk(clk), .reset(rst), .VBKACK_b(ackv[0]), .LINE_CMP(lcmp[0]), .LINE_EN(len[0]),
    .LINEACK_b(ackl[0]), .MCKR_EN(mck[0]), .CLKH(clkh[0]), .CLKV(clkv[0]),
    .HBLANK_b(hb[0]), .VBLANK_b(vb[0]), .HSYNC(hs[0]), .VSYNC(vs[0]), .NXL_b(nxl[0]),
    .VBKINT_b(vint[0]), .LINEINT_b(lint[0]), .FRAME(fr_a));

  video_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(24), .H_ACTIVE(16), .H_SYNC_START(18), .H_SYNC_LEN(3),
    .V_TOTAL(120), .V_ACTIVE(96), .V_SYNC_START(104), .V_SYNC_LEN(3), .SYNC_POL(1), .FW(3)
  ) u_b (
    .clk(clk), .reset(rst), .VBKACK_b(ackv[1]), .LINE_CMP(lcmp[1]), .LINE_EN(len[1]),
    .LINEACK_b(ackl[1]), .MCKR_EN(mck[1]), .CLKH(clkh[1]), .CLKV(clkv[1]),
    .HBLANK_b(hb[1]), .VBLANK_b(vb[1]), .HSYNC(hs[1]), .VSYNC(vs[1]), .NXL_b(nxl[1]),
    .VBKINT_b(vint[1]), .LINEINT_b(lint[1]), .FRAME(fr_b));

  video_timing_gen #(
    .CLK_DIV(4), .H_TOTAL(16), .H_ACTIVE(10), .H_SYNC_START(13), .H_SYNC_LEN(3),
    .V_TOTAL(8), .V_ACTIVE(5), .V_SYNC_START(6), .V_SYNC_LEN(1), .SYNC_POL(0), .FW(4)
  ) u_c (
    .clk(clk), .reset(rst), .VBKACK_b(ackv[2]), .LINE_CMP(lcmp[2]), .LINE_EN(len[2]),
    .LINEACK_b(ackl[2]), .MCKR_EN(mck[2]), .CLKH(clkh[2]), .CLKV(clkv[2]),
    .HBLANK_b(hb[2]), .VBLANK_b(vb[2]), .HSYNC(hs[2]), .VSYNC(vs[2]), .NXL_b(nxl[2]),
    .VBKINT_b(vint[2]), .LINEINT_b(lint[2]), .FRAME(fr_c));

  assign act[0] = {mck[0], clkh[0], clkv[0], hb[0], vb[0], hs[0], vs[0], nxl[0], vint[0], lint[0], fr_a};
  assign act[1] = {mck[1], clkh[1], clkv[1], hb[1], vb[1], hs[1], vs[1], nxl[1], vint[1], lint[1], 5'b0, fr_b};
  assign act[2] = {mck[2], clkh[2], clkv[2], hb[2], vb[2], hs[2], vs[2], nxl[2], vint[2], lint[2], 4'b0, fr_c};

  function automatic out_t raster(geom_t g, longint t);
    out_t   o;
    longint p, h, l, v, f;
    bit     hw, vw;
    p  = t / g.div;
    h  = p % g.ht;
    l  = p / g.ht;
    v  = l % g.vt;
    f  = (l / g.vt) % (longint'(1) << g.fw);
    hw = (h >= g.hss) && (h < g.hss + g.hsl);
    vw = (v >= g.vss) && (v < g.vss + g.vsl);
    o.mck   = (t > 0) && (t % g.div == 0);
    o.h     = 9'(h);
    o.v     = 9'(v);
    o.hb    = (h < g.ha);
    o.vb    = (v < g.va);
    o.hs    = (g.pol != 0) ? hw : !hw;
    o.vs    = (g.pol != 0) ? vw : !vw;
    o.nxl   = (h != g.ht - 1);
    o.vint  = 1'b1;
    o.lint  = 1'b1;
    o.frame = 8'(f);
    return o;
  endfunction

  function automatic logic ack_val(int mode);
    if (mode == 2) return 1'b0;
    if (mode == 1) return ($urandom_range(0, 7) != 0);
    return 1'b1;
  endfunction

  initial begin
    longint t;
    bit     mid, ev_v, ev_l;
    bit     pv[N], pl[N];
    int     vmode[N], lmode[N], hold[N];
    out_t   e;
    G[0] = '{14, 456, 336, 368, 32, 262, 240, 248, 3, 1, 8};
    G[1] = '{2, 24, 16, 18, 3, 120, 96, 104, 3, 1, 3};
    G[2] = '{4, 16, 10, 13, 3, 8, 5, 6, 1, 0, 4};
    for (int i = 0; i < N; i++) begin
      ackv[i] = 1'b1; ackl[i] = 1'b1; len[i] = 1'b1;
      lcmp[i] = 9'(G[i].vt / 2);
      pv[i] = 1'b0; pl[i] = 1'b0;
      vmode[i] = 0; lmode[i] = 0; hold[i] = 0;
    end
    lcmp[1] = 9'd100;
    t = 0;
    for (int cyc = 0; cyc < NCYC && failures < MAXF; cyc++) begin
      @(posedge clk);
      mid = (cyc == 80);
      if (rst || mid) t = 0;
      else t++;
      for (int i = 0; i < N; i++) begin
        e = raster(G[i], t);
        if (rst || mid) begin
          pv[i] = 1'b0;
          pl[i] = 1'b0;
        end else begin
          ev_v = e.mck && (e.h == 0) && (int'(e.v) == G[i].va);
          ev_l = e.mck && (e.h == 0) && (e.v == lcmp[i]) && len[i];
          if (ev_v) pv[i] = 1'b1;
          else if (!ackv[i]) pv[i] = 1'b0;
          if (ev_l) pl[i] = 1'b1;
          else if (!ackl[i]) pl[i] = 1'b0;
        end
        e.vint = !pv[i];
        e.lint = !pl[i];
        sbq[i].push_back(e);
      end
      #1;
      if (mid) rst = 1'b1;
      if (cyc == 3 || cyc == 83) rst = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          vmode[i] = $urandom_range(0, 2);
          lmode[i] = $urandom_range(0, 2);
          hold[i]  = $urandom_range(20, 400);
        end else begin
          hold[i]--;
        end
        ackv[i] = ack_val(vmode[i]);
        ackl[i] = ack_val(lmode[i]);
        len[i]  = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 1499) == 0) begin
          case ($urandom_range(0, 3))
            0:       lcmp[i] = 9'd300;
            1:       lcmp[i] = 9'(G[i].vt);
            default: lcmp[i] = 9'($urandom_range(0, G[i].vt - 1));
          endcase
        end
      end
    end
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    out_t r;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      r = '0;
      r.hb   = 1'b1;
      r.vb   = 1'b1;
      r.hs   = (G[i].pol == 0);
      r.vs   = (G[i].pol == 0);
      r.nxl  = 1'b1;
      r.vint = 1'b1;
      r.lint = 1'b1;
      checks++;
      if (act[i] !== r) begin
        failures++;
        $display("FAIL reset inst%0d act=%h exp=%h", i, act[i], r);
      end
    end
  end

  initial begin
    int n;
    n = 0;
    repeat (100) @(negedge clk);
    while (vint[2] !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL timeout waiting for VBKINT_b inst2 @%0t", $time);
    end
  end

  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (sbq[i].size() != 0) begin
          e = sbq[i].pop_front();
          checks++;
          if (act[i] !== e) begin
            failures++;
            $display("FAIL raster inst%0d @%0t act h=%0d v=%0d word=%h exp h=%0d v=%0d word=%h",
                     i, $time, act[i].h, act[i].v, act[i], e.h, e.v, e);
          end
        end
      end
    end
  end

endmodule
